// File: rtl/cam_val_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cam_val_ctrl
// Purpose  : Valid-bit controller for a 32-entry CAM. It holds one valid bit
//            per entry, which the one-hot write and invalidate vectors update.
//            It qualifies raw tag matches with those valid bits and registers
//            hit, hit index and multi-hit. It also reports occupancy and the
//            lowest free entry to the allocation logic.
// Ports    : clk, rst_n             - clock, async active-low reset
//            wr_dec_i / wr_en_i     - write vector and its qualifier
//            inv_dec_i / inv_en_i   - invalidate vector and its qualifier
//            search_i / match_i     - search pulse and raw compare vector
//            flush_i                - clear-all (only with CAM_VAL_FLUSH_EN)
//            valid_o, count_o       - valid bits and their popcount
//            full_o, empty_o        - occupancy status
//            free_idx_o, free_vld_o - lowest free entry and its qualifier
//            search_done_o, hit_o, hit_idx_o, multi_hit_o - search result
// Options  : `define CAM_VAL_FLUSH_EN adds the flush_i port.
// Revision : 1.0 - initial release
// ============================================================================
module cam_val_ctrl #(
    parameter int ENTRIES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ENTRIES-1:0] wr_dec_i,
    input  logic               wr_en_i,
    input  logic [ENTRIES-1:0] inv_dec_i,
    input  logic               inv_en_i,
    input  logic               search_i,
    input  logic [ENTRIES-1:0] match_i,
`ifdef CAM_VAL_FLUSH_EN
    input  logic               flush_i,
`endif
    output logic [ENTRIES-1:0] valid_o,
    output logic [5:0]         count_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [4:0]         free_idx_o,
    output logic               free_vld_o,
    output logic               search_done_o,
    output logic               hit_o,
    output logic [4:0]         hit_idx_o,
    output logic               multi_hit_o
);

    localparam logic [5:0] c_FULL_COUNT = 6'd32;

    logic [ENTRIES-1:0] r_valid;
    logic [5:0]         r_count;
    logic               r_full;
    logic               r_empty;
    logic [4:0]         r_free_idx;
    logic               r_free_vld;
    logic               r_done;
    logic               r_hit;
    logic [4:0]         r_hit_idx;
    logic               r_multi;

    logic [ENTRIES-1:0] w_next;
    logic [ENTRIES-1:0] w_qual;
    logic [5:0]         w_count;
    logic [4:0]         w_free_idx;
    logic [4:0]         w_hit_idx;

    // Invalidate is applied first and write second, so a write to the same
    // entry in the same cycle leaves that entry valid.
    always_comb begin
        w_next = (r_valid & ~(inv_en_i ? inv_dec_i : '0)) |
                 (wr_en_i ? wr_dec_i : '0);
`ifdef CAM_VAL_FLUSH_EN
        if (flush_i) begin
            w_next = '0;
        end
`endif
    end

    // The search sees the pre-update valid bits. A write in this cycle is
    // therefore invisible to a search issued in the same cycle.
    assign w_qual = match_i & r_valid;

    // Status is derived from the next state so that it registers together
    // with the valid bits and always agrees with valid_o.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_count = w_count + 6'(w_next[i]);
        end
    end

    // Lowest-index priority encoders. Scanning from the top down lets the
    // lowest set bit win, and the result is 0 when no bit is set.
    always_comb begin
        w_free_idx = '0;
        w_hit_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!w_next[i]) begin
                w_free_idx = 5'(i);
            end
            if (w_qual[i]) begin
                w_hit_idx = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_free_idx <= '0;
            r_free_vld <= 1'b1;
            r_done     <= 1'b0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_multi    <= 1'b0;
        end else begin
            r_valid    <= w_next;
            r_count    <= w_count;
            r_full     <= (w_count == c_FULL_COUNT);
            r_empty    <= (w_count == 6'd0);
            r_free_idx <= w_free_idx;
            r_free_vld <= ~&w_next;
            r_done     <= search_i;
            // The result registers hold their value between searches.
            if (search_i) begin
                r_hit     <= |w_qual;
                r_hit_idx <= w_hit_idx;
                // A vector has more than one bit set exactly when clearing
                // its lowest set bit leaves something behind.
                r_multi   <= |(w_qual & (w_qual - 1'b1));
            end
        end
    end

    assign valid_o       = r_valid;
    assign count_o       = r_count;
    assign full_o        = r_full;
    assign empty_o       = r_empty;
    assign free_idx_o    = r_free_idx;
    assign free_vld_o    = r_free_vld;
    assign search_done_o = r_done;
    assign hit_o         = r_hit;
    assign hit_idx_o     = r_hit_idx;
    assign multi_hit_o   = r_multi;

endmodule
`default_nettype wire
